crc_stream_engine: RTL
======================

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 32, CRC width; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter DATA_W, default 32, input beat width; legal values are 8, 16, 32 and 64.
REQ-003 SHALL have parameter POLY, default 32'h04C11DB7, generator polynomial in normal form (low CRC_W bits used).
REQ-004 SHALL have parameter INIT, default 32'hFFFFFFFF, register preset value.
REQ-005 SHALL have parameter REFIN, default 1, which reflects each input byte.
REQ-006 SHALL have parameter REFOUT, default 1, which reflects the final register.
REQ-007 SHALL have parameter XOROUT, default 32'hFFFFFFFF, final XOR mask.
REQ-008 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-009 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port s_valid_i, input, 1 bit: input beat valid.
REQ-011 SHALL have port s_ready_o, output, 1 bit: engine accepts a beat.
REQ-012 SHALL have port s_data_i, input, DATA_W bits: beat data; byte lane 0 (bits 7:0) is first on the wire.
REQ-013 SHALL have port s_keep_i, input, DATA_W/8 bits: byte enables, used on the last beat only.
REQ-014 SHALL have port s_last_i, input, 1 bit: marks the final beat of the frame.
REQ-015 SHALL have port abort_i, input, 1 bit: discards the current frame or result.
REQ-016 SHALL have port crc_valid_o, output, 1 bit: result available.
REQ-017 SHALL have port crc_ready_i, input, 1 bit: result consumer ready.
REQ-018 SHALL have port crc_o, output, CRC_W bits: final CRC value.
REQ-019 SHALL have port busy_o, output, 1 bit: a frame is in progress or a result is pending.

Function
REQ-020 SHALL implement an FSM with three states:
- IDLE: s_ready_o=1.
- RUN: s_ready_o=1.
- DONE: s_ready_o=0, crc_valid_o=1.
REQ-021 A beat SHALL transfer on the cycle where s_valid_i and s_ready_o are both 1; the engine SHALL sustain one beat per cycle.
REQ-022 An accepted beat in IDLE SHALL go to RUN if s_last_i=0, or to DONE if s_last_i=1; an accepted last beat in RUN SHALL go to DONE.
REQ-023 crc_valid_o SHALL assert on the cycle after the last-beat handshake (latency 1) and stay high, with crc_o stable, until crc_ready_i=1.
REQ-024 A result handshake SHALL return the FSM to IDLE and reload the CRC register with INIT.
REQ-025 Each cycle SHALL process the bytes of an accepted beat in lane order, one unrolled byte step per lane.
- Non-last beat: all lanes are processed; s_keep_i is ignored.
- Last beat: only lanes with s_keep_i=1 are processed.
- s_keep_i=0 on a last beat: no bytes are processed; the frame finalises with the register unchanged.
REQ-026 Byte step: if REFIN=1, bits are fed LSB-first; otherwise MSB-first. Shifting SHALL use the CRC_W-bit POLY, modulo 2.
REQ-027 crc_o SHALL equal (REFOUT ? reflect(reg) : reg) XOR XOROUT, truncated to CRC_W bits.
REQ-028 abort_i=1 in any state SHALL force IDLE, reload INIT and deassert crc_valid_o on the next cycle.
REQ-029 abort_i takes priority: a beat or result handshake in the same cycle SHALL be discarded.
REQ-030 busy_o SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-031 A beat offered while in DONE SHALL NOT be consumed; s_valid_i may remain high.

Reset
REQ-032 While rst_ni=0, outputs SHALL be: state IDLE, register INIT, s_ready_o=1, crc_valid_o=0, crc_o=0, busy_o=0.
REQ-033 Reset asserted mid-frame or in DONE SHALL discard all frame state asynchronously; the first frame after reset SHALL compute from INIT.

Configuration
REQ-034 With macro CRC_STREAM_CMP_EN defined:
- Input cmp_crc_i (CRC_W bits) is added; it is sampled on the last-beat handshake.
- Output crc_match_o is added; it is valid with crc_valid_o and equals (crc_o == sampled cmp_crc_i).
- crc_match_o resets to 0.
REQ-035 Without CRC_STREAM_CMP_EN, neither cmp_crc_i nor crc_match_o SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-036 Default parameters, DATA_W=8, bytes "123456789" -> crc_o=0xCBF43926, one cycle after the last beat.
REQ-037 DATA_W=32, "123456789" as three beats, last s_keep_i=4'b0001 -> crc_o=0xCBF43926; with continuous s_valid_i, s_ready_o stays high for all three beats.
REQ-038 CRC_W=16, POLY=0x1021, INIT=0, REFIN=0, REFOUT=0, XOROUT=0, input "123456789" -> 0x31C3.
REQ-039 CRC_W=8, POLY=0x07, all other parameters 0, input "123456789" -> 0xF4.
REQ-040 crc_ready_i held low for 5 cycles after a result -> crc_o stable, s_ready_o=0, busy_o=1, and the next frame's first beat is held off.
REQ-041 abort_i during beat 2 of a frame, then a fresh "123456789" frame -> 0xCBF43926.
REQ-042 rst_ni pulsed mid-frame, then a fresh "123456789" frame -> 0xCBF43926.
REQ-043 With CRC_STREAM_CMP_EN defined: cmp_crc_i=0xCBF43926 -> crc_match_o=1; cmp_crc_i=0 -> crc_match_o=0.

Source files
------------

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC with one unrolled byte step per lane and ready/valid on both sides.
// Optional macro CRC_STREAM_CMP_EN adds cmp_crc_i / crc_match_o for checking against an expected CRC.

module crc_byte_step #(
  parameter int          CRC_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter bit          REFIN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       byte_i,
  input  logic             en_i,
  output logic [CRC_W-1:0] crc_o
);
  logic [CRC_W-1:0] c;
  logic             fb;

  // Normal-form register; REFIN only selects which end of the byte enters first.
  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int b = 0; b < 8; b++) begin
      fb = c[CRC_W-1] ^ (REFIN ? byte_i[b] : byte_i[7-b]);
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : {CRC_W{1'b0}});
    end
    crc_o = en_i ? c : crc_i;
  end
endmodule

module crc_stream_engine #(
  parameter int          CRC_W  = 32,
  parameter int          DATA_W = 32,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter bit          REFIN  = 1'b1,
  parameter bit          REFOUT = 1'b1,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic [DATA_W/8-1:0] s_keep_i,
  input  logic                s_last_i,
  input  logic                abort_i,
  output logic                crc_valid_o,
  input  logic                crc_ready_i,
  output logic [CRC_W-1:0]    crc_o,
  output logic                busy_o
`ifdef CRC_STREAM_CMP_EN
  ,
  input  logic [CRC_W-1:0]    cmp_crc_i,
  output logic                crc_match_o
`endif
);
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic [CRC_W-1:0]                crc_q;
  logic [CRC_W-1:0]                res_q;
  logic [NUM_LANES:0][CRC_W-1:0]   chain;
  logic [NUM_LANES-1:0]            lane_en;
  logic [CRC_W-1:0]                crc_next;
  logic [CRC_W-1:0]                crc_fin;
  logic                            beat_fire;
  logic                            last_fire;
  logic                            res_fire;

  // Abort wins over any handshake in the same cycle.
  assign beat_fire = s_valid_i & s_ready_o & ~abort_i;
  assign last_fire = beat_fire & s_last_i;
  assign res_fire  = crc_valid_o & crc_ready_i & ~abort_i;

  assign chain[0] = crc_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_en[l] = ~s_last_i | s_keep_i[l];
    crc_byte_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .REFIN (REFIN)
    ) u_step (
      .crc_i  (chain[l]),
      .byte_i (s_data_i[8*l +: 8]),
      .en_i   (lane_en[l]),
      .crc_o  (chain[l+1])
    );
  end

  assign crc_next = chain[NUM_LANES];

  function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] r);
    logic [CRC_W-1:0] o;
    for (int i = 0; i < CRC_W; i++) o[i] = REFOUT ? r[CRC_W-1-i] : r[i];
    return o ^ XOROUT[CRC_W-1:0];
  endfunction

  assign crc_fin = finalize(crc_next);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (beat_fire) state_d = s_last_i ? DONE : RUN;
        RUN:     if (last_fire) state_d = DONE;
        DONE:    if (res_fire)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready_o   = (state_q != DONE);
    crc_valid_o = (state_q == DONE);
    busy_o      = (state_q != IDLE);
  end

  // The result is latched at the last beat so crc_o stays stable while DONE waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= INIT[CRC_W-1:0];
      res_q <= '0;
    end else if (abort_i || res_fire) begin
      crc_q <= INIT[CRC_W-1:0];
    end else if (beat_fire) begin
      crc_q <= crc_next;
      if (s_last_i) res_q <= crc_fin;
    end
  end

  assign crc_o = res_q;

`ifdef CRC_STREAM_CMP_EN
  logic match_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  match_q <= 1'b0;
    else if (abort_i || res_fire) match_q <= 1'b0;
    else if (last_fire)           match_q <= (crc_fin == cmp_crc_i);
  end

  assign crc_match_o = match_q;
`endif

endmodule
